// File: rtl/coproc_pkg.sv
// Shared definitions for the coprocessor instruction path: opcodes, field
// positions, matrix-select codes, sequencer state encoding and word legality.
package coproc_pkg;

  localparam int INSTR_W = 22;

  localparam logic [3:0] OP_NOP       = 4'h0;
  localparam logic [3:0] OP_STORE     = 4'h2;
  localparam logic [3:0] OP_ADD       = 4'h3;
  localparam logic [3:0] OP_SUB       = 4'h4;
  localparam logic [3:0] OP_MUL       = 4'h5;
  localparam logic [3:0] OP_TRANSPOSE = 4'h6;
  localparam logic [3:0] OP_OPPOSITE  = 4'h7;
  localparam logic [3:0] OP_SCALAR    = 4'h8;
  localparam logic [3:0] OP_DET2      = 4'h9;
  localparam logic [3:0] OP_DET3      = 4'hA;
  localparam logic [3:0] OP_DET4      = 4'hB;
  localparam logic [3:0] OP_DET5      = 4'hC;

  localparam int OP_LSB   = 0;
  localparam int COL_LSB  = 4;
  localparam int ROW_LSB  = 7;
  localparam int MSEL_LSB = 10;
  localparam int IMM_LSB  = 12;
  localparam int MODE_LSB = 20;

  localparam logic [1:0] MSEL_A    = 2'd0;
  localparam logic [1:0] MSEL_B    = 2'd1;
  localparam logic [1:0] MSEL_C    = 2'd2;
  localparam logic [1:0] MSEL_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  // STORE is the only opcode whose row/col/msel address real storage, so
  // only STORE gets its addressing fields range-checked.
  function automatic logic is_legal(input logic [INSTR_W-1:0] instr, input int mat_dim);
    logic [3:0] op;
    logic [2:0] row;
    logic [2:0] col;
    logic [1:0] msel;
    logic       ok;
    op   = instr[OP_LSB +: 4];
    col  = instr[COL_LSB +: 3];
    row  = instr[ROW_LSB +: 3];
    msel = instr[MSEL_LSB +: 2];
    ok   = 1'b0;
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_TRANSPOSE, OP_OPPOSITE,
      OP_SCALAR, OP_DET2, OP_DET3, OP_DET4, OP_DET5: ok = 1'b1;
      OP_STORE: ok = (msel != MSEL_RSVD) && (int'(row) < mat_dim) && (int'(col) < mat_dim);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Registers a level signal and flags the single cycle where it first goes high.
module rise_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/coproc_instr_decoder.sv
// Latches strobed instruction words, validates them and issues one decoded
// operation at a time to the matrix execution unit.
module coproc_instr_decoder
  import coproc_pkg::*;
#(
  parameter int W_INSTR = 22,
  parameter int MAT_DIM = 5,
  parameter int RET_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W_INSTR-1:0] instr_i,
  input  logic               strobe_i,
  output logic               issue_valid_o,
  input  logic               issue_ready_i,
  output logic [3:0]         op_o,
  output logic [2:0]         col_o,
  output logic [2:0]         row_o,
  output logic [1:0]         msel_o,
  output logic [7:0]         imm_o,
  output logic [1:0]         mode_o,
  input  logic               exec_done_i,
  output logic               busy_o,
  output logic               err_illegal_o,
  output logic               err_overrun_o,
  output logic [RET_W-1:0]   retired_o,
  output logic [1:0]         dbg_state_o
);

  // Handshake: issue_valid_o rises with a legal latched word and, together
  // with every decoded field, holds steady until a cycle with issue_ready_i
  // high; that cycle is the transfer, and valid drops on the next edge.

  state_t             state;
  logic [W_INSTR-1:0] hold;
  logic               strobe_edge;

  rise_edge_det u_edge (
    .clk   (clk),
    .rst   (rst),
    .level (strobe_i),
    .rise  (strobe_edge)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      hold          <= '0;
      issue_valid_o <= 1'b0;
      err_illegal_o <= 1'b0;
      err_overrun_o <= 1'b0;
      retired_o     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (strobe_edge) begin
            if (!is_legal(instr_i, MAT_DIM)) begin
              err_illegal_o <= 1'b1;
            end else begin
              err_illegal_o <= 1'b0;
              err_overrun_o <= 1'b0;
              if (instr_i[OP_LSB +: 4] == OP_NOP) begin
                retired_o <= retired_o + 1'b1;
              end else begin
                hold          <= instr_i;
                issue_valid_o <= 1'b1;
                state         <= ST_ISSUE;
              end
            end
          end
        end
        ST_ISSUE: begin
          if (strobe_edge) err_overrun_o <= 1'b1;
          if (issue_ready_i) begin
            issue_valid_o <= 1'b0;
            hold          <= '0;
            // STORE completes on transfer; everything else waits for the unit.
            if (hold[OP_LSB +: 4] == OP_STORE) begin
              retired_o <= retired_o + 1'b1;
              state     <= ST_IDLE;
            end else begin
              state <= ST_WAIT_DONE;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (strobe_edge) err_overrun_o <= 1'b1;
          if (exec_done_i) begin
            retired_o <= retired_o + 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // hold is only non-zero while issuing, so the fields read 0 otherwise.
  assign op_o        = hold[OP_LSB +: 4];
  assign col_o       = hold[COL_LSB +: 3];
  assign row_o       = hold[ROW_LSB +: 3];
  assign msel_o      = hold[MSEL_LSB +: 2];
  assign imm_o       = hold[IMM_LSB +: 8];
  assign mode_o      = hold[MODE_LSB +: 2];
  assign busy_o      = (state != ST_IDLE);
  assign dbg_state_o = state;

endmodule

// File: tb/tb_coproc_instr_decoder.sv
// Directed bench for coproc_instr_decoder with hand-computed expectations.
module tb_coproc_instr_decoder;

  logic        clk;
  logic        rst;
  logic [21:0] instr_i;
  logic        strobe_i;
  logic        issue_valid_o;
  logic        issue_ready_i;
  logic [3:0]  op_o;
  logic [2:0]  col_o;
  logic [2:0]  row_o;
  logic [1:0]  msel_o;
  logic [7:0]  imm_o;
  logic [1:0]  mode_o;
  logic        exec_done_i;
  logic        busy_o;
  logic        err_illegal_o;
  logic        err_overrun_o;
  logic [7:0]  retired_o;
  logic [1:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_ret;

  coproc_instr_decoder #(.W_INSTR(22), .MAT_DIM(5), .RET_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_i       (instr_i),
    .strobe_i      (strobe_i),
    .issue_valid_o (issue_valid_o),
    .issue_ready_i (issue_ready_i),
    .op_o          (op_o),
    .col_o         (col_o),
    .row_o         (row_o),
    .msel_o        (msel_o),
    .imm_o         (imm_o),
    .mode_o        (mode_o),
    .exec_done_i   (exec_done_i),
    .busy_o        (busy_o),
    .err_illegal_o (err_illegal_o),
    .err_overrun_o (err_overrun_o),
    .retired_o     (retired_o),
    .dbg_state_o   (dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [21:0] mk(input logic [1:0] mode, input logic [7:0] imm,
                                     input logic [1:0] msel, input logic [2:0] row,
                                     input logic [2:0] col, input logic [3:0] op);
    return {mode, imm, msel, row, col, op};
  endfunction

  // Raise strobe with a word for one cycle; returns just after the edge cycle.
  task automatic pulse(input logic [21:0] word);
    instr_i  = word;
    strobe_i = 1'b1;
    step();
    strobe_i = 1'b0;
  endtask

  initial begin
    int issues;
    rst = 1'b1; instr_i = '0; strobe_i = 1'b0; issue_ready_i = 1'b0; exec_done_i = 1'b0;
    exp_ret = 8'd0;
    step(); step();
    rst = 1'b0;
    step();
    check("rst_valid", issue_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ret", retired_o, 0);
    check("rst_state", dbg_state_o, 0);

    // STORE issued and accepted immediately
    issue_ready_i = 1'b1;
    pulse(22'h201002);
    check("st_valid", issue_valid_o, 1);
    check("st_op", op_o, 2);
    check("st_msel", msel_o, 0);
    check("st_row", row_o, 0);
    check("st_col", col_o, 0);
    check("st_imm", imm_o, 1);
    check("st_mode", mode_o, 2);
    check("st_busy1", busy_o, 1);
    step();
    exp_ret = exp_ret + 1;
    check("st_valid_drop", issue_valid_o, 0);
    check("st_ret", retired_o, exp_ret);
    check("st_busy0", busy_o, 0);
    check("st_op_zero", op_o, 0);

    // ADD stalled by ready, then completion
    issue_ready_i = 1'b0;
    pulse(22'h000003);
    for (int i = 0; i < 3; i++) begin
      check("add_stall_valid", issue_valid_o, 1);
      check("add_stall_op", op_o, 3);
      check("add_stall_busy", busy_o, 1);
      step();
    end
    issue_ready_i = 1'b1;
    step();
    issue_ready_i = 1'b0;
    check("add_wait_valid", issue_valid_o, 0);
    check("add_wait_state", dbg_state_o, 2);
    for (int i = 0; i < 4; i++) begin
      check("add_wait_busy", busy_o, 1);
      check("add_wait_ret", retired_o, exp_ret);
      step();
    end
    exec_done_i = 1'b1;
    step();
    exec_done_i = 1'b0;
    exp_ret = exp_ret + 1;
    check("add_done_ret", retired_o, exp_ret);
    check("add_done_busy", busy_o, 0);

    // illegal words, then clearing NOP
    pulse(22'h00000F);
    check("ill_op_flag", err_illegal_o, 1);
    check("ill_op_valid", issue_valid_o, 0);
    check("ill_op_busy", busy_o, 0);
    step();
    pulse(mk(2'd0, 8'd0, 2'd0, 3'd5, 3'd0, 4'h2));
    check("ill_row_flag", err_illegal_o, 1);
    check("ill_row_valid", issue_valid_o, 0);
    step();
    pulse(mk(2'd0, 8'd0, 2'd3, 3'd1, 3'd1, 4'h2));
    check("ill_msel_flag", err_illegal_o, 1);
    check("ill_msel_ret", retired_o, exp_ret);
    step();
    pulse(22'h000000);
    exp_ret = exp_ret + 1;
    check("nop_clear", err_illegal_o, 0);
    check("nop_ret", retired_o, exp_ret);
    check("nop_valid", issue_valid_o, 0);
    step();

    // overrun during MUL's WAIT_DONE
    issue_ready_i = 1'b1;
    pulse(22'h000005);
    check("mul_op", op_o, 5);
    step();
    check("mul_wait", dbg_state_o, 2);
    pulse(mk(2'd0, 8'd7, 2'd1, 3'd1, 3'd1, 4'h2));
    check("ovr_flag", err_overrun_o, 1);
    check("ovr_valid", issue_valid_o, 0);
    check("ovr_busy", busy_o, 1);
    step();
    check("ovr_no_issue", issue_valid_o, 0);
    exec_done_i = 1'b1;
    step();
    exec_done_i = 1'b0;
    exp_ret = exp_ret + 1;
    check("mul_ret", retired_o, exp_ret);
    check("ovr_sticky", err_overrun_o, 1);
    step();
    check("ovr_store_dropped", issue_valid_o, 0);
    check("ovr_ret_same", retired_o, exp_ret);

    // strobe held high for 20 cycles -> one issue
    issues = 0;
    instr_i  = mk(2'd1, 8'h80, 2'd1, 3'd4, 3'd4, 4'h2);
    strobe_i = 1'b1;
    step();
    check("hold_imm", imm_o, 8'h80);
    check("hold_row", row_o, 4);
    check("hold_ovr_clr", err_overrun_o, 0);
    for (int i = 0; i < 20; i++) begin
      if (issue_valid_o && issue_ready_i) issues++;
      step();
    end
    strobe_i = 1'b0;
    exp_ret = exp_ret + 1;
    check("hold_issues", issues, 1);
    check("hold_ret", retired_o, exp_ret);
    step();

    // edge coinciding with ISSUE->IDLE is an overrun
    issue_ready_i = 1'b0;
    pulse(mk(2'd0, 8'd3, 2'd2, 3'd2, 3'd2, 4'h2));
    step();
    issue_ready_i = 1'b1;
    instr_i  = 22'h000003;
    strobe_i = 1'b1;
    step();
    strobe_i = 1'b0;
    exp_ret = exp_ret + 1;
    check("bnd_ovr", err_overrun_o, 1);
    check("bnd_ret", retired_o, exp_ret);
    check("bnd_idle", busy_o, 0);
    step();
    check("bnd_no_issue", issue_valid_o, 0);

    // reset during WAIT_DONE
    pulse(22'h000009);
    step();
    check("det2_wait", dbg_state_o, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_ret = 8'd0;
    check("mrst_state", dbg_state_o, 0);
    check("mrst_busy", busy_o, 0);
    check("mrst_ret", retired_o, 0);
    check("mrst_ovr", err_overrun_o, 0);
    check("mrst_ill", err_illegal_o, 0);
    check("mrst_valid", issue_valid_o, 0);
    exec_done_i = 1'b1;
    step();
    exec_done_i = 1'b0;
    check("late_done", retired_o, 0);

    // counter wrap
    for (int i = 0; i < 255; i++) begin
      pulse(22'h000000);
      step();
    end
    check("ret_255", retired_o, 8'd255);
    pulse(22'h000000);
    check("ret_wrap", retired_o, 8'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Bound the run in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/coproc_instr_decoder.md
Name: coproc_instr_decoder

Overview:
- Coprocessor-side receiver for the 22-bit instruction word that the board-level sequencer presents alongside a debounced "execute" strobe.
- Detects each strobe rising edge, latches and validates the word, decodes its fields and issues one operation at a time to the matrix execution unit over a valid/ready handshake.
- For multi-cycle operations, holds the instruction until the unit reports completion.
- Exposes busy/error/retire status for the seven-segment display path.

Parameters:
- W_INSTR, 22, instruction word width
- MAT_DIM, 5, matrix dimension; valid row/col indices are 0..MAT_DIM-1
- RET_W, 8, width of the retired-instruction counter

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- instr_i  in  22  instruction word; sampled only on a strobe rising edge
- strobe_i  in  1  debounced execute level, synchronous to clk
- issue_valid_o  out  1  decoded operation available
- issue_ready_i  in  1  execution unit accepts the operation
- op_o  out  4  opcode, instr[3:0]
- col_o  out  3  column index, instr[6:4]
- row_o  out  3  row index, instr[9:7]
- msel_o  out  2  matrix select, instr[11:10] (0=A, 1=B, 2=C, 3=reserved)
- imm_o  out  8  signed element/scalar value, instr[19:12]
- mode_o  out  2  packing/size field, instr[21:20]
- exec_done_i  in  1  one-cycle pulse: multi-cycle op finished
- busy_o  out  1  high in any state other than IDLE
- err_illegal_o  out  1  sticky: last strobed word rejected
- err_overrun_o  out  1  sticky: strobe edge arrived while busy
- retired_o  out  RET_W  count of completed instructions, wraps

Behaviour:
- Reset (any cycle, any state): state=IDLE; all outputs 0; strobe_q=0; holding register cleared; a pending handshake is abandoned.
- Edge detect: edge = strobe_i & ~strobe_q, with strobe_q registered every cycle. A held-high strobe yields exactly one edge.
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE + edge:
  - Latch instr_i.
  - Illegal word: set err_illegal_o, stay in IDLE.
  - Legal word: clear both error flags, go to ISSUE.
  - issue_valid_o rises the cycle after the edge (latency 1).
- Illegal word, any of:
  - opcode not in {0000 NOP, 0010 STORE, 0011 ADD, 0100 SUB, 0101 MUL, 0110 TRANSPOSE, 0111 OPPOSITE, 1000 SCALAR, 1001 DET2, 1010 DET3, 1011 DET4, 1100 DET5}
  - STORE with msel=3
  - STORE with row or col >= MAT_DIM
- NOP: legal, never issued. Increments retired_o the cycle after the edge, stays in IDLE.
- ISSUE:
  - issue_valid_o=1; all decoded outputs stable and equal to the latched word until the handshake.
  - valid&ready: STORE increments retired_o and goes to IDLE; every other opcode goes to WAIT_DONE.
  - issue_valid_o drops the cycle after the handshake.
- WAIT_DONE: issue_valid_o=0, busy_o=1. On exec_done_i, increment retired_o and go to IDLE.
- exec_done_i outside WAIT_DONE is ignored.
- Edge in ISSUE or WAIT_DONE: the word is dropped and err_overrun_o is set; the in-flight op is unaffected.
- Edge in the same cycle that WAIT_DONE→IDLE or ISSUE→IDLE: counts as busy, so it is dropped and flags overrun.
- retired_o wraps from 2^RET_W-1 to 0.
- Decoded outputs are 0 whenever issue_valid_o=0.

Decomposition:
- Shared package coproc_pkg:
  - opcode localparams (OP_NOP … OP_DET5)
  - field bit positions
  - msel encodings
  - state encoding
  - legality function is_legal(instr, MAT_DIM)
- The execution unit and the instruction sequencer import the same package.
- One sub-module, rise_edge_det (strobe register + edge output); everything else stays in one module.

Test Plan:
- Reset, then strobe STORE 10_00000001_00_000_000_0010 with ready=1 → valid at edge+1: op=2, msel=0, row=0, col=0, imm=1, mode=2; retired_o=1; busy_o=0 two cycles after the edge.
- Strobe ADD (0x000003) with ready held 0 for 3 cycles, then 1; exec_done_i 5 cycles later → fields stable throughout the stall; retired_o increments only on done; busy_o=1 from edge+1 until done+1.
- Strobe opcode 1111, then a STORE with row=5 → err_illegal_o=1 after each, no issue; a following legal NOP clears it and retired_o+1.
- During WAIT_DONE of MUL (0x000005), pulse strobe with a STORE → err_overrun_o=1; STORE never issued; MUL completes normally.
- Hold strobe_i high for 20 cycles with a STORE → exactly one issue; retired_o+1.
- Assert rst during WAIT_DONE → next cycle all outputs 0, IDLE; a later exec_done_i does not change retired_o. Also preload 255 retires → next retire yields retired_o=0.
